// File: rtl/crc5_check_if.sv
// Byte-stream bus between the receive aligner and the CRC5 checker.
// The master drives frame bytes; the slave reports the check result.
interface crc5_check_if;
  logic       enable;
  logic [7:0] din;
  logic       done;
  logic       pass;
  logic       err;
  logic [4:0] crc_out;
  logic [7:0] len;

  modport master (
    output enable, din,
    input  done, pass, err, crc_out, len
  );

  modport slave (
    input  enable, din,
    output done, pass, err, crc_out, len
  );
endinterface

// File: rtl/crc5_check.sv
// Receive-side CRC5 checker (x^5 + x^2 + 1, init 5'h1F, one byte per cycle).
// The last byte of each enable window is the transmitted CRC byte {3'b000, crc}.
//
//   state | meaning
//   WAIT  | idle, waiting for the first byte of a frame
//   WORK  | frame in progress, folding each byte one cycle late
//   DONE  | done pulse cycle; a new frame may start here
module crc5_check (
  input  logic        clk,
  input  logic        rst_n,
  crc5_check_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [4:0] r_crc;
  logic [7:0] r_hold;
  logic [7:0] r_len;
  logic       r_done;
  logic       r_pass;
  logic       r_err;

  state_t     w_state;
  logic [4:0] w_crc;
  logic [7:0] w_hold;
  logic [7:0] w_len;
  logic       w_done;
  logic       w_pass;
  logic       w_err;
  logic       w_match;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] n;
    n[0] = c[0] ^ c[2] ^ c[3] ^ d[0] ^ d[3] ^ d[5] ^ d[6];
    n[1] = c[1] ^ c[3] ^ c[4] ^ d[1] ^ d[4] ^ d[6] ^ d[7];
    n[2] = c[0] ^ c[3] ^ c[4] ^ d[0] ^ d[2] ^ d[3] ^ d[6] ^ d[7];
    n[3] = c[0] ^ c[1] ^ c[4] ^ d[1] ^ d[3] ^ d[4] ^ d[7];
    n[4] = c[1] ^ c[2] ^ d[2] ^ d[4] ^ d[5];
    return n;
  endfunction

  // The held byte is the CRC byte once enable drops; a lone byte has no payload.
  assign w_match = (r_len >= 8'd2) && (r_hold[7:5] == 3'b000) && (r_hold[4:0] == r_crc);

  always_comb begin
    w_state = r_state;
    w_crc   = r_crc;
    w_hold  = r_hold;
    w_len   = r_len;
    w_done  = 1'b0;
    w_pass  = r_pass;
    w_err   = r_err;
    case (r_state)
      WAIT, DONE: begin
        if (bus.enable) begin
          w_state = WORK;
          w_crc   = 5'h1F;
          w_hold  = bus.din;
          w_len   = 8'd1;
        end else begin
          w_state = WAIT;
        end
      end
      WORK: begin
        if (bus.enable) begin
          w_crc  = crc5_step(r_crc, r_hold);
          w_hold = bus.din;
          w_len  = (r_len == 8'hFF) ? 8'hFF : r_len + 8'd1;
        end else begin
          w_state = DONE;
          w_done  = 1'b1;
          w_pass  = w_match;
          w_err   = !w_match;
        end
      end
      default: w_state = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
      r_crc   <= 5'h1F;
      r_hold  <= 8'h00;
      r_len   <= 8'h00;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_crc   <= w_crc;
      r_hold  <= w_hold;
      r_len   <= w_len;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_err   <= w_err;
    end
  end

  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.err     = r_err;
  assign bus.crc_out = r_crc;
  assign bus.len     = r_len;

endmodule

// File: tb/tb_crc5_check.sv
// Directed bench for crc5_check: known-good/bad frames, reset abort, long frame.
module tb_crc5_check;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [7:0] frame_q[$];

  crc5_check_if bus ();

  crc5_check dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_step(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] n;
    n[0] = c[0] ^ c[2] ^ c[3] ^ d[0] ^ d[3] ^ d[5] ^ d[6];
    n[1] = c[1] ^ c[3] ^ c[4] ^ d[1] ^ d[4] ^ d[6] ^ d[7];
    n[2] = c[0] ^ c[3] ^ c[4] ^ d[0] ^ d[2] ^ d[3] ^ d[6] ^ d[7];
    n[3] = c[0] ^ c[1] ^ c[4] ^ d[1] ^ d[3] ^ d[4] ^ d[7];
    n[4] = c[1] ^ c[2] ^ d[2] ^ d[4] ^ d[5];
    return n;
  endfunction

  // Drives frame_q one byte per cycle, then drops enable; returns at the negedge
  // before the edge that registers the result.
  task automatic send_frame();
    foreach (frame_q[i]) begin
      @(negedge clk);
      bus.enable = 1'b1;
      bus.din    = frame_q[i];
    end
    @(negedge clk);
    bus.enable = 1'b0;
    bus.din    = 8'h00;
  endtask

  task automatic chk_result(input string tag, input logic exp_pass,
                            input logic [4:0] exp_crc, input logic [7:0] exp_len);
    @(negedge clk);
    chk({tag, ".done"}, bus.done, 1'b1);
    chk({tag, ".pass"}, bus.pass, exp_pass);
    chk({tag, ".err"},  bus.err,  !exp_pass);
    chk({tag, ".crc"},  bus.crc_out, exp_crc);
    chk({tag, ".len"},  bus.len,  exp_len);
  endtask

  int         pulses;
  logic [4:0] long_crc;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.din    = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.pass", bus.pass, 1'b0);
    chk("rst.err",  bus.err,  1'b0);
    chk("rst.crc",  bus.crc_out, 5'h1F);
    chk("rst.len",  bus.len,  8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // f(1F,00) = 0F
    frame_q = '{8'h00, 8'h0F};
    send_frame();
    chk_result("good1", 1'b1, 5'h0F, 8'd2);
    @(negedge clk);
    chk("good1.pulse", bus.done, 1'b0);
    chk("good1.hold",  bus.pass, 1'b1);

    // f(1F,FF) = 1B; second frame's first byte lands on the done cycle
    frame_q = '{8'hFF, 8'h1B};
    send_frame();
    @(negedge clk);
    chk("b2b1.done", bus.done, 1'b1);
    chk("b2b1.pass", bus.pass, 1'b1);
    chk("b2b1.crc",  bus.crc_out, 5'h1B);
    bus.enable = 1'b1;
    bus.din    = 8'h00;
    frame_q = '{8'h00, 8'h01};
    send_frame();
    chk_result("b2b2", 1'b1, 5'h01, 8'd3);

    frame_q = '{8'h00, 8'h0E};
    send_frame();
    chk_result("badcrc", 1'b0, 5'h0F, 8'd2);

    frame_q = '{8'h00, 8'h2F};
    send_frame();
    chk_result("badpad", 1'b0, 5'h0F, 8'd2);

    frame_q = '{8'h0F};
    send_frame();
    chk_result("single", 1'b0, 5'h1F, 8'd1);

    // Reset during byte 2 of a 4-byte frame
    @(negedge clk);
    bus.enable = 1'b1;
    bus.din    = 8'h12;
    @(negedge clk);
    bus.din    = 8'h34;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.done", bus.done, 1'b0);
    chk("abort.pass", bus.pass, 1'b0);
    chk("abort.err",  bus.err,  1'b0);
    chk("abort.crc",  bus.crc_out, 5'h1F);
    chk("abort.len",  bus.len,  8'd0);
    @(negedge clk);
    bus.din = 8'h56;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.din    = 8'h00;
    rst_n      = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("abort.nodone", pulses, 0);

    frame_q = '{8'h00, 8'h0F};
    send_frame();
    chk_result("postrst", 1'b1, 5'h0F, 8'd2);

    // 299 zero bytes plus the CRC byte: 300 bytes, len saturates
    long_crc = 5'h1F;
    frame_q.delete();
    for (int i = 0; i < 299; i++) begin
      frame_q.push_back(8'h00);
      long_crc = ref_step(long_crc, 8'h00);
    end
    frame_q.push_back({3'b000, long_crc});
    send_frame();
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("long.pulses", pulses, 1);
    chk("long.pass", bus.pass, 1'b1);
    chk("long.err",  bus.err,  1'b0);
    chk("long.crc",  bus.crc_out, long_crc);
    chk("long.len",  bus.len,  8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
